// File: rtl/mult_seq_if.sv
// mult_seq_if: request/result bundle between a host and the sequential multiplier.
interface mult_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             doMult;
    logic             busy;
    logic             mult_done;
    logic [WIDTH-1:0] out_lo;
    logic [WIDTH-1:0] out_hi;
    logic             out_ovf;

    modport master (
        output a, b, is_signed, doMult,
        input  busy, mult_done, out_lo, out_hi, out_ovf
    );

    modport slave (
        input  a, b, is_signed, doMult,
        output busy, mult_done, out_lo, out_hi, out_ovf
    );
endinterface

// File: rtl/mult_seq.sv
// mult_seq: sequential shift-add multiplier, signed/unsigned, double-width product.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    mult_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   mcand, mag_a, mag_b, hi, lo;
    logic [2*WIDTH:0]   acc, acc_n;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic               neg, sgn, last, accept, ovf;

    always_ff @(posedge clk) state <= reset ? IDLE : state_n;

    // The edge leaving DONE may accept a new request, giving a WIDTH+1 cycle period
    always_comb begin
        accept  = bus.doMult && (state == IDLE || state == DONE);
        last    = cnt == CW'(WIDTH - 1);
        state_n = (state == RUN) ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
        mag_a   = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b   = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        sum     = acc[2*WIDTH:WIDTH] + {1'b0, acc[0] ? mcand : {WIDTH{1'b0}}};
        acc_n   = {1'b0, sum, acc[WIDTH-1:1]};
        prod    = neg ? -acc_n[2*WIDTH-1:0] : acc_n[2*WIDTH-1:0];
        {hi, lo} = prod;
        ovf     = sgn ? (hi != {WIDTH{lo[WIDTH-1]}}) : (hi != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.busy      <= 1'b0;
            bus.mult_done <= 1'b0;
            bus.out_lo    <= '0;
            bus.out_hi    <= '0;
            bus.out_ovf   <= 1'b0;
            mcand         <= '0;
            acc           <= '0;
            cnt           <= '0;
            neg           <= 1'b0;
            sgn           <= 1'b0;
        end else begin
            bus.busy      <= state_n != IDLE;
            bus.mult_done <= state_n == DONE;
            if (accept) begin
                mcand <= mag_a;
                acc   <= {{(WIDTH + 1){1'b0}}, mag_b};
                cnt   <= '0;
                neg   <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                sgn   <= bus.is_signed;
            end else if (state == RUN) begin
                acc <= acc_n;
                cnt <= cnt + CW'(1);
                if (last) begin
                    bus.out_hi  <= hi;
                    bus.out_lo  <= lo;
                    bus.out_ovf <= ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed scoreboard bench for 32-bit and 8-bit mult_seq instances.
module tb_mult_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_seq_if #(.WIDTH(32)) if32();
    mult_seq_if #(.WIDTH(8))  if8();

    mult_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
    mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        ovf;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference product from wide signed arithmetic; overflow judged by numeric range
    function automatic exp_t model(logic [63:0] a, logic [63:0] b, int w, bit s);
        logic signed [129:0] sa, sb, p, one, lim;
        exp_t e;
        one = 1;
        sa  = a;
        sb  = b;
        if (s && a[w-1]) sa = sa - (one <<< w);
        if (s && b[w-1]) sb = sb - (one <<< w);
        p     = sa * sb;
        lim   = one <<< (w - 1);
        e.ovf = s ? (p < -lim || p >= lim) : (p >= (one <<< w));
        p     = p & ((one <<< (2 * w)) - 1);
        e.lo  = 64'(p & ((one <<< w) - 1));
        e.hi  = 64'(p >>> w);
        return e;
    endfunction

    task automatic cmp(bit w8);
        exp_t e;
        if ((w8 ? q8.size() : q32.size()) == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = w8 ? q8.pop_front() : q32.pop_front();
            chk("out_hi", w8 ? {56'b0, if8.out_hi} : {32'b0, if32.out_hi}, e.hi);
            chk("out_lo", w8 ? {56'b0, if8.out_lo} : {32'b0, if32.out_lo}, e.lo);
            chk("out_ovf", w8 ? if8.out_ovf : if32.out_ovf, e.ovf);
        end
    endtask

    task automatic issue(bit w8, logic [63:0] a, logic [63:0] b, bit s);
        if (w8) begin
            if8.a = a[7:0]; if8.b = b[7:0]; if8.is_signed = s; if8.doMult = 1'b1;
            q8.push_back(model(a, b, 8, s));
        end else begin
            if32.a = a[31:0]; if32.b = b[31:0]; if32.is_signed = s; if32.doMult = 1'b1;
            q32.push_back(model(a, b, 32, s));
        end
        @(negedge clk);
        if8.doMult  = 1'b0;
        if32.doMult = 1'b0;
        chk("busy_after_accept", w8 ? if8.busy : if32.busy, 1);
    endtask

    task automatic await(bit w8, int k0);
        int k = k0;
        while (!(w8 ? if8.mult_done : if32.mult_done) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, w8 ? 8 : 32);
        cmp(w8);
    endtask

    initial begin
        int n, t, last;
        if32.a = '0; if32.b = '0; if32.is_signed = 1'b0; if32.doMult = 1'b0;
        if8.a = '0;  if8.b = '0;  if8.is_signed = 1'b0;  if8.doMult = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", if32.busy, 0);
        chk("rst_done", if32.mult_done, 0);
        chk("rst_lo", if32.out_lo, 0);
        chk("rst_hi", if32.out_hi, 0);
        chk("rst_ovf", if32.out_ovf, 0);
        reset = 1'b0;
        @(negedge clk);

        issue(0, 1, 5, 0);
        await(0, 0);
        @(negedge clk);
        chk("done_one_cycle", if32.mult_done, 0);
        chk("busy_cleared", if32.busy, 0);

        issue(0, 32'hFFFF_FFFF, 5, 1);
        await(0, 0);
        issue(0, 32'hFFFF_FFFF, 5, 0);
        await(0, 0);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        await(0, 0);
        issue(0, 32'h8000_0000, 32'h8000_0000, 1);
        await(0, 0);
        issue(0, 32'h8000_0000, 1, 1);
        await(0, 0);
        issue(0, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 1);
        await(0, 0);

        // Request mid-run must be dropped; operand changes after accept must not matter
        issue(0, 3, 7, 0);
        repeat (5) @(negedge clk);
        if32.a = 9; if32.b = 9; if32.doMult = 1'b1;
        @(negedge clk);
        if32.doMult = 1'b0; if32.a = $urandom; if32.b = $urandom; if32.is_signed = 1'b1;
        await(0, 6);
        issue(0, 32'h1234, 32'h10, 0);
        await(0, 0);

        issue(0, 1234, 5678, 0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", if32.busy, 0);
        chk("abort_done", if32.mult_done, 0);
        chk("abort_lo", if32.out_lo, 0);
        chk("abort_hi", if32.out_hi, 0);
        chk("abort_ovf", if32.out_ovf, 0);
        void'(q32.pop_front());
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (if32.mult_done) n++;
        end
        chk("abort_no_done", n, 0);
        issue(0, 6, 7, 0);
        await(0, 0);

        issue(1, 8'hFF, 8'hFF, 1);
        await(1, 0);
        issue(1, 8'hFF, 8'hFF, 0);
        await(1, 0);
        issue(1, 8'h80, 8'h80, 1);
        await(1, 0);

        if8.a = 8'hFF; if8.b = 8'h0F; if8.is_signed = 1'b0; if8.doMult = 1'b1;
        q8.push_back(model(64'hFF, 64'h0F, 8, 0));
        @(negedge clk);
        n = 0; t = 0; last = 0;
        while (n < 3 && t < 100) begin
            @(negedge clk);
            t++;
            if (if8.mult_done) begin
                chk("b2b_gap", t - last, n == 0 ? 8 : 9);
                last = t;
                cmp(1);
                n++;
                if (n < 3) q8.push_back(model(64'hFF, 64'h0F, 8, 0));
                else if8.doMult = 1'b0;
            end
        end
        chk("b2b_count", n, 3);
        @(negedge clk);
        chk("b2b_idle", if8.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
